// File: rtl/time_digit_scanner_if.sv
// time_digit_scanner_if
//   Display-side bundle between the time counters and the 4-digit scanner.
//   data_show   : {valid, hour[4:0], minute[5:0]} binary display word
//   byte_status : [0] blank hour-tens zero, [1] blink enable, [2] lamp test
//   segment     : gfedcba segment lines, active-high
//   bytee       : one-hot digit enable, active-high
//   master drives the word and status; slave (the scanner) drives the display lines.
interface time_digit_scanner_if;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic [6:0]  segment;
  logic [3:0]  bytee;

  modport master (
    output data_show,
    output byte_status,
    input  segment,
    input  bytee
  );

  modport slave (
    input  data_show,
    input  byte_status,
    output segment,
    output bytee
  );
endinterface

// File: rtl/time_digit_scanner.sv
// time_digit_scanner
//   Converts the binary HH:MM display word to BCD with a sequential shift-add-3
//   engine, then time-multiplexes four 7-segment digits (common-enable scan).
//   Supports blink, hour-tens leading-zero blanking and lamp test.
// Ports
//   clock_i : system clock, all logic on posedge
//   reset_i : synchronous, active-high
//   bus     : time_digit_scanner_if.slave (data_show, byte_status in; segment, bytee out)
//
// Converter states
//   state    | meaning
//   S_IDLE   | watch for a new valid word, capture operands
//   S_SHIFT  | six shift/add-3 steps on hour and minute in parallel
//   S_COMMIT | write all four digits atomically, mark display valid
module time_digit_scanner #(
  parameter int SCAN_DIV    = 1024,
  parameter int BLINK_SLOTS = 512
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  time_digit_scanner_if.slave   bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [3:0] DASH = 4'hA;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t       state_q;
  logic [2:0]   bit_cnt_q;
  logic [5:0]   hr_bin_q, mn_bin_q;
  logic [7:0]   hr_bcd_q, mn_bcd_q;
  logic         range_err_q;
  logic [10:0]  last_word_q;
  logic         last_ok_q;
  logic [3:0]   dig_q [4];
  logic         committed_valid_q;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    slot_q, slot_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [6:0]    segment_q, segment_d;
  logic [3:0]    bytee_q, bytee_d;

  logic [4:0] hour_in;
  logic [5:0] minute_in;
  logic       valid_in;

  assign valid_in  = bus.data_show[11];
  assign hour_in   = bus.data_show[10:6];
  assign minute_in = bus.data_show[5:0];

  function automatic logic [7:0] add3(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      DASH:    return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  // Converter FSM
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q           <= S_IDLE;
      bit_cnt_q         <= '0;
      hr_bin_q          <= '0;
      mn_bin_q          <= '0;
      hr_bcd_q          <= '0;
      mn_bcd_q          <= '0;
      range_err_q       <= 1'b0;
      last_word_q       <= '0;
      last_ok_q         <= 1'b0;
      committed_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_in) begin
            // last_ok_q lets a cleared history reconvert even an all-zero word
            if (!last_ok_q || (bus.data_show[10:0] != last_word_q)) begin
              hr_bin_q    <= {1'b0, hour_in};
              mn_bin_q    <= minute_in;
              hr_bcd_q    <= '0;
              mn_bcd_q    <= '0;
              range_err_q <= (hour_in > 5'd23) || (minute_in > 6'd59);
              last_word_q <= bus.data_show[10:0];
              last_ok_q   <= 1'b1;
              bit_cnt_q   <= '0;
              state_q     <= S_SHIFT;
            end
          end else begin
            committed_valid_q <= 1'b0;
            last_word_q       <= '0;
            last_ok_q         <= 1'b0;
          end
        end
        S_SHIFT: begin
          // adjust first, then shift the next binary MSB into the BCD LSB
          {hr_bcd_q, hr_bin_q} <= {add3(hr_bcd_q), hr_bin_q} << 1;
          {mn_bcd_q, mn_bin_q} <= {add3(mn_bcd_q), mn_bin_q} << 1;
          if (bit_cnt_q == 3'd5) begin
            state_q <= S_COMMIT;
          end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        S_COMMIT: begin
          if (range_err_q) begin
            for (int i = 0; i < 4; i++) dig_q[i] <= DASH;
          end else begin
            dig_q[0] <= mn_bcd_q[3:0];
            dig_q[1] <= mn_bcd_q[7:4];
            dig_q[2] <= hr_bcd_q[3:0];
            dig_q[3] <= hr_bcd_q[7:4];
          end
          committed_valid_q <= 1'b1;
          state_q           <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Scan prescaler, slot and blink phase
  logic presc_tc;
  assign presc_tc = (presc_q == PW'(SCAN_DIV - 1));

  always_comb begin
    presc_d     = presc_q + PW'(1);
    slot_d      = slot_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (presc_tc) begin
      presc_d = '0;
      slot_d  = slot_q + 2'd1;
      if (blink_cnt_q == BW'(BLINK_SLOTS - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Output priority: lamp test > no data > blink off-phase > hour-tens blank > digit
  logic [3:0] slot_onehot;
  assign slot_onehot = 4'b0001 << slot_q;

  always_comb begin
    segment_d = decode(dig_q[slot_q]);
    bytee_d   = slot_onehot;
    if (bus.byte_status[2]) begin
      segment_d = 7'h7F;
      bytee_d   = slot_onehot;
    end else if (!committed_valid_q) begin
      segment_d = '0;
      bytee_d   = '0;
    end else if (bus.byte_status[1] && blink_ph_q) begin
      segment_d = '0;
      bytee_d   = '0;
    end else if ((slot_q == 2'd3) && bus.byte_status[0] && (dig_q[3] == 4'd0)) begin
      segment_d = '0;
      bytee_d   = 4'b1000;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      presc_q     <= '0;
      slot_q      <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      segment_q   <= '0;
      bytee_q     <= '0;
    end else begin
      presc_q     <= presc_d;
      slot_q      <= slot_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      segment_q   <= segment_d;
      bytee_q     <= bytee_d;
    end
  end

  assign bus.segment = segment_q;
  assign bus.bytee   = bytee_q;

endmodule
